// File: rtl/shram_pkg.sv
// Shared definitions for the main/sub Z80 shared work-RAM arbiter.
// Contents:
//   state_t        - arbiter FSM states (IDLE, ACC, FIN)
//   P0 / P1        - port indices used for the owner and last_grant registers
//   DEF_AW/DEF_DW  - default RAM address and data widths (2 KiB x 8)
package shram_pkg;

    localparam int DEF_AW = 11;
    localparam int DEF_DW = 8;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/shram_port.sv
// Per-CPU side of the shared RAM arbiter.
// Tracks whether the current CPU bus cycle has already been given its RAM
// access, produces the pending flag for the arbiter and the WAIT request for
// the CPU, and holds the registered read data returned to the CPU.
// Ports:
//   clk, reset_in  - system clock, synchronous active-high reset
//   req            - decoded shared-RAM request (sel & (rd | wr))
//   done           - this port's access is in its final cycle
//   rdata_load     - capture rdata into din this cycle (read accesses)
//   rdata          - RAM read data
//   pend           - request present and not yet served
//   pause          - stall to the CPU WAIT input
//   din            - registered read data to the CPU
module shram_port
    import shram_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset_in,
    input  logic          req,
    input  logic          done,
    input  logic          rdata_load,
    input  logic [DW-1:0] rdata,
    output logic          pend,
    output logic          pause,
    output logic [DW-1:0] din
);

    logic served;

    // A held strobe must not trigger a second access: served latches on
    // completion and only clears once the CPU releases its strobe.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            served <= 1'b0;
            din    <= '0;
        end else begin
            served <= req & (served | done);
            if (rdata_load) begin
                din <= rdata;
            end
        end
    end

    assign pend  = req & ~served;
    assign pause = pend & ~reset_in;

endmodule

// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter letting the main and sub Z80 share one single-port
// synchronous RAM. Each granted access takes two cycles: ACC presents the
// address (and write pulse), FIN captures read data and releases the CPU.
// A CPU is held on WAIT while its request is pending.
// Ports:
//   clk, reset_in             - system clock, synchronous active-high reset
//   cpuN_sel/rd/wr            - shared-RAM decode hit and memory strobes
//   cpuN_adr, cpuN_dout       - CPU address and write data
//   cpuN_din, cpuN_pause      - registered read data and WAIT request
//   ram_adr/ram_we/ram_wdata  - RAM address, one-cycle write pulse, write data
//   ram_rdata                 - RAM read data, one cycle after ram_adr
module shared_ram_arbiter
    import shram_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset_in,
    input  logic          cpu0_sel,
    input  logic          cpu1_sel,
    input  logic          cpu0_rd,
    input  logic          cpu1_rd,
    input  logic          cpu0_wr,
    input  logic          cpu1_wr,
    input  logic [AW-1:0] cpu0_adr,
    input  logic [AW-1:0] cpu1_adr,
    input  logic [DW-1:0] cpu0_dout,
    input  logic [DW-1:0] cpu1_dout,
    output logic [DW-1:0] cpu0_din,
    output logic [DW-1:0] cpu1_din,
    output logic          cpu0_pause,
    output logic          cpu1_pause,
    output logic [AW-1:0] ram_adr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    state_t state;
    logic   owner;
    logic   last_grant;
    logic   acc_wr;

    logic   req0, req1;
    logic   pend0, pend1;
    logic   done0, done1;
    logic   load0, load1;

    logic          grant_valid;
    logic          grant_port;
    logic [AW-1:0] grant_adr;
    logic [DW-1:0] grant_wdata;
    logic          grant_wr;

    assign req0 = cpu0_sel & (cpu0_rd | cpu0_wr);
    assign req1 = cpu1_sel & (cpu1_rd | cpu1_wr);

    assign done0 = (state == FIN) && (owner == P0);
    assign done1 = (state == FIN) && (owner == P1);
    assign load0 = done0 && !acc_wr;
    assign load1 = done1 && !acc_wr;

    shram_port #(.DW(DW)) u_port0 (
        .clk        (clk),
        .reset_in   (reset_in),
        .req        (req0),
        .done       (done0),
        .rdata_load (load0),
        .rdata      (ram_rdata),
        .pend       (pend0),
        .pause      (cpu0_pause),
        .din        (cpu0_din)
    );

    shram_port #(.DW(DW)) u_port1 (
        .clk        (clk),
        .reset_in   (reset_in),
        .req        (req1),
        .done       (done1),
        .rdata_load (load1),
        .rdata      (ram_rdata),
        .pend       (pend1),
        .pause      (cpu1_pause),
        .din        (cpu1_din)
    );

    // Grant decision. From IDLE a tie goes to the port that was not served
    // last; from FIN only the other port may be chained, which gives strict
    // alternation under continuous contention.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = P0;
        case (state)
            IDLE: begin
                grant_valid = pend0 | pend1;
                grant_port  = (pend0 & pend1) ? ~last_grant : pend1;
            end
            FIN: begin
                grant_valid = (owner == P0) ? pend1 : pend0;
                grant_port  = ~owner;
            end
            default: begin
                grant_valid = 1'b0;
                grant_port  = P0;
            end
        endcase
    end

    assign grant_adr   = (grant_port == P1) ? cpu1_adr  : cpu0_adr;
    assign grant_wdata = (grant_port == P1) ? cpu1_dout : cpu0_dout;
    assign grant_wr    = (grant_port == P1) ? cpu1_wr   : cpu0_wr;

    // RAM-side outputs are loaded on the grant edge so they are already
    // valid during ACC; ram_adr holds afterwards and ram_we is a single
    // pulse. Reset drops everything back to IDLE, aborting an access.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state      <= IDLE;
            owner      <= P0;
            last_grant <= P1;
            acc_wr     <= 1'b0;
            ram_adr    <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                ACC: begin
                    state <= FIN;
                end
                FIN: begin
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (grant_valid) begin
                state     <= ACC;
                owner     <= grant_port;
                acc_wr    <= grant_wr;
                ram_adr   <= grant_adr;
                ram_wdata <= grant_wdata;
                ram_we    <= grant_wr;
            end
        end
    end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Self-checking bench for shared_ram_arbiter.
// A bench-side RAM serves the DUT; a transaction-level reference model
// (own memory copy, per-port served flags, current access and its phase)
// predicts every output and is compared on each falling edge. Directed
// sequences pin key behaviour with literal expectations, then randomized
// CPU traffic with occasional aborts and resets runs against the model.
module tb_shared_ram_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk;
    logic          reset_in;
    logic          cpu0_sel, cpu1_sel;
    logic          cpu0_rd, cpu1_rd;
    logic          cpu0_wr, cpu1_wr;
    logic [AW-1:0] cpu0_adr, cpu1_adr;
    logic [DW-1:0] cpu0_dout, cpu1_dout;
    logic [DW-1:0] cpu0_din, cpu1_din;
    logic          cpu0_pause, cpu1_pause;
    logic [AW-1:0] ram_adr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int tests = 0;
    int fails = 0;

    shared_ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .cpu0_sel   (cpu0_sel),
        .cpu1_sel   (cpu1_sel),
        .cpu0_rd    (cpu0_rd),
        .cpu1_rd    (cpu1_rd),
        .cpu0_wr    (cpu0_wr),
        .cpu1_wr    (cpu1_wr),
        .cpu0_adr   (cpu0_adr),
        .cpu1_adr   (cpu1_adr),
        .cpu0_dout  (cpu0_dout),
        .cpu1_dout  (cpu1_dout),
        .cpu0_din   (cpu0_din),
        .cpu1_din   (cpu1_din),
        .cpu0_pause (cpu0_pause),
        .cpu1_pause (cpu1_pause),
        .ram_adr    (ram_adr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench RAM: synchronous single port, read data one cycle after address.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_adr] <= ram_wdata;
        ram_rdata <= mem[ram_adr];
    end

    // Reference model state. m_phase: 0 no access, 1 address cycle, 2 data cycle.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_valid = 1'b0;
    bit            m_served [2];
    int            m_owner = 0;
    int            m_phase = 0;
    int            m_last  = 1;
    bit            m_wr;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_ram_adr;
    logic [DW-1:0] m_din [2];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Model advance: one RAM access per CPU bus cycle, two cycles per access,
    // round-robin on ties, chaining straight to the other port if it waits.
    always @(posedge clk) begin : model
        bit rq [2];
        bit pd [2];
        int g;
        rq[0] = cpu0_sel & (cpu0_rd | cpu0_wr);
        rq[1] = cpu1_sel & (cpu1_rd | cpu1_wr);
        if (m_phase == 1 && m_wr) ref_mem[m_adr] = m_data;
        if (reset_in) begin
            m_phase   = 0;
            m_last    = 1;
            m_served  = '{1'b0, 1'b0};
            m_din     = '{8'h00, 8'h00};
            m_ram_adr = '0;
        end else begin
            pd[0] = rq[0] && !m_served[0];
            pd[1] = rq[1] && !m_served[1];
            g = -1;
            if (m_phase == 2) begin
                if (!m_wr) m_din[m_owner] = ref_mem[m_adr];
                if (rq[m_owner]) m_served[m_owner] = 1'b1;
                m_last  = m_owner;
                m_phase = 0;
                if (pd[1 - m_owner]) g = 1 - m_owner;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else begin
                if (pd[0] && pd[1]) g = 1 - m_last;
                else if (pd[0])     g = 0;
                else if (pd[1])     g = 1;
            end
            if (!rq[0]) m_served[0] = 1'b0;
            if (!rq[1]) m_served[1] = 1'b0;
            if (g >= 0) begin
                m_owner   = g;
                m_phase   = 1;
                m_wr      = (g == 0) ? cpu0_wr   : cpu1_wr;
                m_adr     = (g == 0) ? cpu0_adr  : cpu1_adr;
                m_data    = (g == 0) ? cpu0_dout : cpu1_dout;
                m_ram_adr = m_adr;
            end
        end
        m_valid = 1'b1;
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        bit r0, r1;
        if (m_valid) begin
            r0 = cpu0_sel & (cpu0_rd | cpu0_wr);
            r1 = cpu1_sel & (cpu1_rd | cpu1_wr);
            checkOutput("cpu0_pause", {31'd0, cpu0_pause}, {31'd0, (!reset_in && r0 && !m_served[0])});
            checkOutput("cpu1_pause", {31'd0, cpu1_pause}, {31'd0, (!reset_in && r1 && !m_served[1])});
            checkOutput("ram_we", {31'd0, ram_we}, {31'd0, (m_phase == 1 && m_wr)});
            checkOutput("ram_adr", 32'(ram_adr), 32'(m_ram_adr));
            if (m_phase == 1 && m_wr) checkOutput("ram_wdata", 32'(ram_wdata), 32'(m_data));
            checkOutput("cpu0_din", 32'(cpu0_din), 32'(m_din[0]));
            checkOutput("cpu1_din", 32'(cpu1_din), 32'(m_din[1]));
        end
    end

    task automatic applyStimulus(input int p, input bit sel, input bit rd, input bit wr,
                                 input logic [AW-1:0] adr, input logic [DW-1:0] dout);
        if (p == 0) begin
            cpu0_sel = sel; cpu0_rd = rd; cpu0_wr = wr; cpu0_adr = adr; cpu0_dout = dout;
        end else begin
            cpu1_sel = sel; cpu1_rd = rd; cpu1_wr = wr; cpu1_adr = adr; cpu1_dout = dout;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (4) tick();
    endtask

    function automatic bit reqOf(input int p);
        return (p == 0) ? (cpu0_sel & (cpu0_rd | cpu0_wr)) : (cpu1_sel & (cpu1_rd | cpu1_wr));
    endfunction

    task automatic randPort(input int p);
        bit w;
        if (reqOf(p)) begin
            if (m_served[p] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0))
                applyStimulus(p, 1'b0, 1'b0, 1'b0, '0, '0);
        end else if ($urandom_range(0, 2) == 0) begin
            w = 1'($urandom_range(0, 1));
            applyStimulus(p, $urandom_range(0, 7) != 0, !w, w, AW'($urandom_range(0, 31)), DW'($urandom));
        end
    endtask

    initial begin
        int wecnt, p0cnt, p1cnt, seen, alt_err, first_port, last_port, port, n0, n1;
        logic [AW-1:0] prev_adr;

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[11'h123] = 8'hA5; ref_mem[11'h123] = 8'hA5;
        mem[11'h7FF] = 8'h00; ref_mem[11'h7FF] = 8'h00;

        // Reset held with both requests up.
        reset_in = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 11'h010, 8'h00);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 11'h420, 8'h00);
        repeat (3) begin
            tick();
            @(negedge clk);
            checkOutput("rst_pause0", {31'd0, cpu0_pause}, 32'd0);
            checkOutput("rst_pause1", {31'd0, cpu1_pause}, 32'd0);
            checkOutput("rst_ram_we", {31'd0, ram_we}, 32'd0);
            checkOutput("rst_ram_adr", 32'(ram_adr), 32'd0);
            checkOutput("rst_din0", 32'(cpu0_din), 32'd0);
            checkOutput("rst_din1", 32'(cpu1_din), 32'd0);
        end
        tick();
        reset_in = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_pause0", {31'd0, cpu0_pause}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("post_rst_first_grant", 32'(ram_adr), 32'h010);
        drain();

        // Single read with strobe held 6 cycles.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 11'h123, 8'h00);
        @(negedge clk);
        checkOutput("rd_pause_k", {31'd0, cpu0_pause}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("rd_adr_k1", 32'(ram_adr), 32'h123);
        tick();
        @(negedge clk);
        checkOutput("rd_pause_k2", {31'd0, cpu0_pause}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("rd_din_k3", 32'(cpu0_din), 32'hA5);
        checkOutput("rd_pause_k3", {31'd0, cpu0_pause}, 32'd0);
        tick(); tick();
        @(negedge clk);
        checkOutput("rd_pause_k5", {31'd0, cpu0_pause}, 32'd0);
        tick();
        drain();

        // cpu1 write then cpu0 read-back.
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 11'h7FF, 8'h5A);
        wecnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ram_we) begin
                wecnt++;
                checkOutput("wr_wdata", 32'(ram_wdata), 32'h5A);
                checkOutput("wr_adr", 32'(ram_adr), 32'h7FF);
            end
            tick();
        end
        checkOutput("wr_pulse_count", 32'(wecnt), 32'd1);
        drain();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 11'h7FF, 8'h00);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("wr_readback", 32'(cpu0_din), 32'h5A);
        tick();
        drain();

        // cpu1 solo read so cpu1 is the last grant; the tie then goes to cpu0.
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 11'h100, 8'h00);
        repeat (3) tick();
        drain();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 11'h011, 8'h00);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 11'h422, 8'h00);
        p0cnt = 0; p1cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            p0cnt += int'(cpu0_pause);
            p1cnt += int'(cpu1_pause);
            if (i == 1) checkOutput("tie_first_cpu0", 32'(ram_adr), 32'h011);
            if (i == 3) checkOutput("tie_second_cpu1", 32'(ram_adr), 32'h422);
            tick();
        end
        checkOutput("tie_pause0_len", 32'(p0cnt), 32'd3);
        checkOutput("tie_pause1_len", 32'(p1cnt), 32'd5);
        drain();
        // cpu0 solo, then the next tie goes to cpu1.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 11'h012, 8'h00);
        repeat (3) tick();
        drain();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 11'h013, 8'h00);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 11'h423, 8'h00);
        tick();
        @(negedge clk);
        checkOutput("tie2_first_cpu1", 32'(ram_adr), 32'h423);
        tick();
        drain();

        // Continuous contention: both CPUs re-request right after each release.
        n0 = 0; n1 = 0; seen = 0; alt_err = 0; first_port = -1; last_port = -1;
        prev_adr = ram_adr;
        for (int i = 0; i < 24; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (reqOf(p) && m_served[p]) applyStimulus(p, 1'b0, 1'b0, 1'b0, '0, '0);
                else if (!reqOf(p)) begin
                    if (p == 0) begin applyStimulus(0, 1'b1, 1'b1, 1'b0, AW'(n0), 8'h00); n0++; end
                    else        begin applyStimulus(1, 1'b1, 1'b1, 1'b0, AW'(11'h400 + n1), 8'h00); n1++; end
                end
            end
            @(negedge clk);
            if (ram_adr !== prev_adr) begin
                seen++;
                port = int'(ram_adr[AW-1]);
                if (last_port >= 0 && port == last_port) alt_err++;
                if (first_port < 0) first_port = port;
                last_port = port;
                prev_adr  = ram_adr;
            end
            tick();
        end
        checkOutput("cont_access_count", 32'(seen), 32'd12);
        checkOutput("cont_alternation", 32'(alt_err), 32'd0);
        checkOutput("cont_first_port", 32'(first_port), 32'd0);
        drain();

        // cpu1 drops its write during ACC: still committed, new request re-served.
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 11'h055, 8'h66);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("abort_we_in_acc", {31'd0, ram_we}, 32'd1);
        tick(); tick();
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 11'h056, 8'h77);
        @(negedge clk);
        checkOutput("abort_rereq_pause", {31'd0, cpu1_pause}, 32'd1);
        checkOutput("abort_committed", 32'(mem[11'h055]), 32'h66);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("abort_rereq_done", {31'd0, cpu1_pause}, 32'd0);
        checkOutput("abort_rereq_data", 32'(mem[11'h056]), 32'h77);
        tick();
        drain();

        // Reset asserted during ACC.
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 11'h200, 8'h99);
        tick();
        reset_in = 1'b1;
        @(negedge clk);
        checkOutput("rst_acc_pause0", {31'd0, cpu0_pause}, 32'd0);
        tick();
        wecnt = 0;
        @(negedge clk);
        wecnt += int'(ram_we);
        tick();
        reset_in = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wecnt += int'(ram_we);
            tick();
        end
        checkOutput("rst_acc_no_more_we", 32'(wecnt), 32'd0);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 11'h300, 8'h00);
        tick();
        @(negedge clk);
        checkOutput("rst_acc_idle_after", 32'(ram_adr), 32'h300);
        tick();
        drain();

        // Randomized traffic with occasional aborts and resets.
        for (int i = 0; i < 1500; i++) begin
            if (reset_in) reset_in = 1'b0;
            else if ($urandom_range(0, 149) == 0) reset_in = 1'b1;
            randPort(0);
            randPort(1);
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
